// File: rtl/lcd_nibble_receiver.sv
// rtl/lcd_nibble_receiver.sv - HD44780-style bus snooper: rebuilds bytes from the LCD strobe, decodes commands, mirrors display RAM
module lcd_nibble_receiver #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       db4,
    input  logic       db5,
    input  logic       db6,
    input  logic       db7,
    input  logic       rs,
    input  logic       enable,
    output logic [7:0] byte_out,
    output logic       byte_is_data,
    output logic       byte_valid,
    output logic       four_bit_mode,
    output logic       busy,
    output logic       protocol_error,
    output logic [4:0] cursor,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char
);

    // Fewer than two stages would leave the asynchronous bus metastable.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    logic [5:0] sync_q [STAGES];
    logic       en_prev_q;
    logic [3:0] nib_s;
    logic       en_s;
    logic       rs_s;
    logic       fall;

    state_t     state_q, state_d;
    logic [4:0] clr_addr_q, clr_addr_d;

    logic [7:0] byte_out_q, byte_out_d;
    logic       is_data_q, is_data_d;
    logic       valid_q, valid_d;
    logic       four_bit_q, four_bit_d;
    logic       phase_q, phase_d;
    logic [3:0] hi_nib_q, hi_nib_d;
    logic       hi_rs_q, hi_rs_d;
    logic       perr_q, perr_d;
    logic [4:0] cursor_q, cursor_d;
    logic       incr_q, incr_d;

    logic       is_instr;
    logic       dec_clear, dec_home, dec_entry, dec_func, dec_addr, dec_char;

    logic [7:0] ram_q [32];
    logic       ram_we;
    logic [4:0] ram_waddr;
    logic [7:0] ram_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
            en_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= {rs, enable, db7, db6, db5, db4};
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
            en_prev_q <= sync_q[STAGES-1][4];
        end
    end

    assign nib_s = sync_q[STAGES-1][3:0];
    assign en_s  = sync_q[STAGES-1][4];
    assign rs_s  = sync_q[STAGES-1][5];
    assign fall  = en_prev_q & ~en_s;

    // Commands take effect in the cycle their byte is presented on byte_out.
    assign is_instr  = valid_q & ~is_data_q;
    assign dec_clear = is_instr && (byte_out_q == 8'h01);
    assign dec_home  = is_instr && (byte_out_q[7:1] == 7'b0000001);
    assign dec_entry = is_instr && (byte_out_q[7:2] == 6'b000001);
    assign dec_func  = is_instr && (byte_out_q[7:5] == 3'b001);
    assign dec_addr  = is_instr && byte_out_q[7];
    assign dec_char  = valid_q & is_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (dec_clear) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + 5'd1;
                if (clr_addr_q == 5'd31) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_CLEAR);
        ram_we    = busy | dec_char;
        ram_waddr = busy ? clr_addr_q : cursor_q;
        ram_wdata = busy ? 8'h20 : byte_out_q;
    end

    always_comb begin
        byte_out_d = byte_out_q;
        is_data_d  = is_data_q;
        valid_d    = 1'b0;
        four_bit_d = four_bit_q;
        phase_d    = phase_q;
        hi_nib_d   = hi_nib_q;
        hi_rs_d    = hi_rs_q;
        perr_d     = perr_q;
        cursor_d   = cursor_q;
        incr_d     = incr_q;

        if (fall) begin
            if (busy) begin
                perr_d = 1'b1;
            end else if (!four_bit_q) begin
                byte_out_d = {nib_s, 4'h0};
                is_data_d  = rs_s;
                valid_d    = 1'b1;
            end else if (!phase_q) begin
                hi_nib_d = nib_s;
                hi_rs_d  = rs_s;
                phase_d  = 1'b1;
            end else begin
                byte_out_d = {hi_nib_q, nib_s};
                is_data_d  = hi_rs_q;
                valid_d    = 1'b1;
                phase_d    = 1'b0;
                if (rs_s != hi_rs_q) perr_d = 1'b1;
            end
        end

        if (dec_clear) begin
            cursor_d = '0;
            incr_d   = 1'b1;
        end
        if (dec_home) cursor_d = '0;
        if (dec_entry) incr_d = byte_out_q[1];
        if (dec_func) begin
            four_bit_d = ~byte_out_q[4];
            if (!byte_out_q[4]) phase_d = 1'b0;
        end
        if (dec_addr) cursor_d = {byte_out_q[6], byte_out_q[3:0]};
        if (dec_char) cursor_d = incr_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_out_q <= '0;
            is_data_q  <= 1'b0;
            valid_q    <= 1'b0;
            four_bit_q <= 1'b0;
            phase_q    <= 1'b0;
            hi_nib_q   <= '0;
            hi_rs_q    <= 1'b0;
            perr_q     <= 1'b0;
            cursor_q   <= '0;
            incr_q     <= 1'b1;
        end else begin
            byte_out_q <= byte_out_d;
            is_data_q  <= is_data_d;
            valid_q    <= valid_d;
            four_bit_q <= four_bit_d;
            phase_q    <= phase_d;
            hi_nib_q   <= hi_nib_d;
            hi_rs_q    <= hi_rs_d;
            perr_q     <= perr_d;
            cursor_q   <= cursor_d;
            incr_q     <= incr_d;
        end
    end

    // Display RAM survives reset; only a clear command initializes it.
    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ram_waddr] <= ram_wdata;
    end

    assign rd_char        = ram_q[rd_addr];
    assign byte_out       = byte_out_q;
    assign byte_is_data   = is_data_q;
    assign byte_valid     = valid_q;
    assign four_bit_mode  = four_bit_q;
    assign protocol_error = perr_q;
    assign cursor         = cursor_q;

endmodule

// File: doc/lcd_nibble_receiver.md
LCD_NIBBLE_RECEIVER -- requirements
Module: lcd_nibble_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops (min 2).
REQ-002 SHALL have port clk  in  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports db4, db5, db6, db7  in  1 each  LCD data bus bits; nibble = {db7,db6,db5,db4}.
REQ-005 SHALL have port rs  in  1  register select (0 = instruction, 1 = character data).
REQ-006 SHALL have port enable  in  1  LCD strobe; data is latched on its falling edge.
REQ-007 SHALL have port byte_out  out  8  last assembled byte.
REQ-008 SHALL have port byte_is_data  out  1  rs value that accompanied byte_out.
REQ-009 SHALL have port byte_valid  out  1  one-cycle strobe marking a new byte_out.
REQ-010 SHALL have port four_bit_mode  out  1  high once the 4-bit interface is selected.
REQ-011 SHALL have port busy  out  1  high while the display RAM is being cleared.
REQ-012 SHALL have port protocol_error  out  1  sticky flag for rs mismatch between nibbles or a strobe received while busy.
REQ-013 SHALL have port cursor  out  5  current display RAM address.
REQ-014 SHALL have ports rd_addr  in  5, rd_char  out  8  combinational read port into 32-entry display RAM.

Function
REQ-015 SHALL pass db4-db7, rs and enable through SYNC_STAGES flops; all decoding uses the synchronized copies.
REQ-016 SHALL detect an enable falling edge as synchronized enable previous = 1, current = 0, and act on the data/rs sampled in that same cycle.
REQ-017 SHALL, in 8-bit mode (four_bit_mode = 0), treat each falling edge as a full byte {nibble, 4'h0}.
REQ-018 SHALL, in 4-bit mode, take the first falling edge as the high nibble and the second as the low nibble; a phase bit tracks which one is expected.
REQ-019 SHALL set protocol_error if rs at the low nibble differs from rs at the high nibble; the byte then uses the high-nibble rs.
REQ-020 SHALL assert byte_valid for exactly one cycle, one cycle after the completing falling edge, with byte_out and byte_is_data updated in that same cycle.
REQ-021 SHALL decode instruction bytes (rs = 0), applied in the cycle byte_valid is asserted:
- 0x01 clear: busy = 1; write 0x20 to all 32 RAM entries, one per cycle, at addresses 0 to 31; busy = 0 after the 32nd write; cursor = 0; increment = 1.
- 0x02/0x03 home: cursor = 0.
- 0x04-0x07 entry mode: increment = bit1.
- 0x20-0x3F function set: bit4 = 0 selects 4-bit mode and sets phase to high; bit4 = 1 selects 8-bit mode.
- 0x80-0xFF set address: cursor = {bit6, bit3..bit0}.
- All other codes: ignored.
REQ-022 SHALL, on character data (rs = 1), write byte_out to ram[cursor], then cursor + 1 if increment = 1, else cursor - 1, modulo 32 (31 wraps to 0, 0 wraps to 31).
REQ-023 SHALL, on a falling edge while busy, drop the strobe (no byte, no phase advance) and set protocol_error.
REQ-024 SHALL, when an 8-bit-mode 0x2 nibble switches to 4-bit mode, emit byte 0x20 and expect the high nibble next.
REQ-025 SHALL leave RAM contents uninitialized until the first clear; rd_char reflects writes on the cycle after the write.

Reset
REQ-026 SHALL, on reset_n low, asynchronously set: byte_out = 0, byte_is_data = 0, byte_valid = 0, four_bit_mode = 0, phase = high, busy = 0, protocol_error = 0, cursor = 0, increment = 1, synchronizers = 0.
REQ-027 SHALL, on reset mid-clear or mid-nibble-pair, abandon the operation; RAM is not re-cleared by reset.

Verification
REQ-028 SHALL test: 8-bit nibbles 0x3, 0x3, 0x3, then 0x2 -> three bytes 0x30, a byte 0x20, four_bit_mode = 1.
REQ-029 SHALL test: 4-bit mode, rs = 1, nibbles 0x4 then 0x1 -> byte_out = 0x41, byte_is_data = 1, ram[0] = 0x41, cursor = 1.
REQ-030 SHALL test: instruction 0x01 -> busy for 32 cycles, all rd_char = 0x20, cursor = 0; an enable strobe during busy -> protocol_error = 1, no byte_valid.
REQ-031 SHALL test: entry 0x04, address 0x80, write 'A' -> cursor = 31; address 0xCF, increment mode, write -> cursor wraps to 0.
REQ-032 SHALL test: high nibble with rs = 1, low nibble with rs = 0 -> protocol_error = 1, byte_is_data = 1.
REQ-033 SHALL test: reset_n pulsed between high and low nibble -> four_bit_mode = 0, byte_valid never asserted for the split byte.
